rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
- Registered RISC-V (RV32I/RV64I, optional M) decode stage between instruction fetch and execute.
- Converts a 32-bit instruction and its PC into structured control fields, a sign-extended immediate and a branch/jump target.
- Uses valid/ready handshakes on both sides, with a 2-entry skid buffer so full throughput survives backpressure.
- Supports pipeline flush and keeps a saturating illegal-instruction counter.

Parameters:
XLEN, 64, datapath width (32 or 64); selects RV32I or RV64I legality and immediate sign-extension width.
CNT_W, 16, width of the illegal-instruction counter.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous active-low reset.
in_valid  input  1  fetch presents an instruction.
in_ready  output  1  stage can accept an instruction.
in_instr  input  32  raw instruction word.
in_pc  input  XLEN  PC of in_instr.
flush  input  1  discard all buffered instructions.
out_valid  output  1  decoded bundle valid.
out_ready  input  1  execute accepts the bundle.
out_pc  output  XLEN  PC of the bundle.
out_rd, out_rs1, out_rs2  output  5 each  register indices; out_rd=0 when the instruction does not write a register.
out_imm  output  XLEN  sign-extended immediate.
out_target  output  XLEN  out_pc+out_imm for B/J formats, else 0.
out_alu_op  output  5  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 MUL, 11 MULH, 12 MULHSU, 13 MULHU, 14 DIV, 15 DIVU, 16 REM, 17 REMU, 18 LUI, 19 AUIPC.
out_fmt  output  3  0 R, 1 I, 2 S, 3 B, 4 U, 5 J.
out_is_load, out_is_store, out_is_branch, out_is_jump, out_is_word  output  1 each  class flags; out_is_jump covers both JAL and JALR.
out_br_cond  output  3  funct3 of branches, else 0.
out_mem_size  output  2  0 byte, 1 half, 2 word, 3 double.
out_mem_unsigned  output  1  LBU/LHU/LWU.
out_illegal  output  1  undecodable instruction.
illegal_cnt  output  CNT_W  saturating count of illegal bundles accepted downstream.

Behaviour:
- Reset (async, reset_n low): both buffer entries invalid, out_valid=0, in_ready=1, all out_* fields 0, illegal_cnt=0.
- Decode is combinational on in_instr; results are registered. Latency is 1 cycle from in_valid&&in_ready to out_valid.
- Buffer:
  - The output register holds the head bundle; the skid register holds the overflow entry.
  - in_ready = !skid_valid (registered, no combinational path from out_ready).
  - If the head is stalled (out_valid && !out_ready) and an input arrives, the input goes into the skid register.
  - When the head drains, skid moves to the head.
  - Simultaneous drain and accept with skid empty: the new bundle goes straight to the head.
  - Order is always preserved; no bundle is dropped or duplicated.
- flush: both entries are invalidated next cycle and in_ready=1. An input offered in the same cycle as flush is discarded. flush has priority over every other event.
- Immediates: I, S, B, U and J per the ISA, sign-extended from instr[31] to XLEN. B and J have bit0=0. U is instr[31:12]<<12, sign-extended.
- Register and format rules:
  - Stores and branches: out_rd=0.
  - LUI/AUIPC/JAL: out_rs1=0, out_rs2=0.
  - I-type: out_rs2=0.
  - JALR: out_target=0; execute computes the target.
- Illegal conditions:
  - Unknown opcode.
  - Unlisted funct3/funct7 combination.
  - XLEN=32: opcodes 0111011 and 0011011, LD, SD, LWU, and shamt[5]=1.
  - XLEN=64: SLLI/SRLI/SRAI funct6 other than 000000/010000.
- Illegal bundle: out_illegal=1, out_rd=0, all class flags 0, out_alu_op=0, out_pc kept.
- illegal_cnt increments on out_valid && out_ready && out_illegal and saturates at all-ones.

Optional Feature:
- Macro: RV_M_EXT_EN.
- Defined: funct7=0000001 on opcodes 0110011 and 0111011 decodes to alu_op 10-17, with out_is_word on the W forms. XLEN=32 keeps the W forms illegal.
- Undefined: every funct7=0000001 R-type instruction is illegal and increments illegal_cnt.

Test Plan:
1. 0xFFF00513 (addi a0,zero,-1), pc=0x100, out_ready=1 -> next cycle out_valid=1, rd=10, rs1=0, fmt=1, alu_op=0, imm=0xFFFFFFFFFFFFFFFF.
2. 0xFE051EE3 (bne a0,zero,-4), pc=0x1000 -> is_branch=1, br_cond=1, rd=0, imm=-4, target=0x0FFC.
3. Backpressure: out_ready=0, 3 instructions offered back-to-back -> in_ready=0 after the 2nd is accepted, 3rd held by fetch. Then out_ready=1 -> bundles emerge in order over 3 consecutive cycles, none lost.
4. Both entries full, flush=1 -> next cycle out_valid=0, in_ready=1; the following instruction appears normally 1 cycle after acceptance.
5. 0x00000000, then 0x0005B503 (ld) with XLEN=32 -> both out_illegal=1, illegal_cnt=2. With XLEN=64, ld decodes as is_load=1, mem_size=3.
6. 0x02C58533 (mul a0,a1,a2) -> alu_op=10 with RV_M_EXT_EN, out_illegal=1 without it. Assert reset_n low mid-stream -> outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - registered RV32I/RV64I decode stage with 2-entry skid buffer
// Optional M extension decode is enabled by defining RV_M_EXT_EN.
module rv_decode_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_target,
  output logic [4:0]       out_alu_op,
  output logic [2:0]       out_fmt,
  output logic             out_is_load,
  output logic             out_is_store,
  output logic             out_is_branch,
  output logic             out_is_jump,
  output logic             out_is_word,
  output logic [2:0]       out_br_cond,
  output logic [1:0]       out_mem_size,
  output logic             out_mem_unsigned,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

`ifdef RV_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif
  localparam bit RV64 = (XLEN == 64);

  localparam logic [2:0] FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2,
                         FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] target;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      alu_op;
    logic [2:0]      fmt;
    logic [2:0]      br_cond;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jump;
    logic            is_word;
    logic [1:0]      mem_size;
    logic            mem_unsigned;
    logic            illegal;
  } bundle_t;

  // base ALU op from funct3; alt selects SUB/SRA
  function automatic logic [4:0] base_op(input logic [2:0] f, input logic alt);
    case (f)
      3'd0:    base_op = alt ? 5'd1 : 5'd0;
      3'd1:    base_op = 5'd2;
      3'd2:    base_op = 5'd3;
      3'd3:    base_op = 5'd4;
      3'd4:    base_op = 5'd5;
      3'd5:    base_op = alt ? 5'd7 : 5'd6;
      3'd6:    base_op = 5'd8;
      default: base_op = 5'd9;
    endcase
  endfunction

  logic [6:0]      opcode, f7;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic            sh_ok, legal;
  bundle_t         dec, head, skid;
  logic            head_valid, skid_valid, accept, drain;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{(XLEN-12){in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {{(XLEN-31){in_instr[31]}}, in_instr[30:12], 12'b0};
  assign imm_j  = {{(XLEN-20){in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};

  // RV64 shifts carry a 6-bit shamt, so only funct6 is checked there
  assign sh_ok = RV64 ? (in_instr[31:26] == 6'b000000 ||
                         (in_instr[31:26] == 6'b010000 && f3 == 3'd5))
                      : (f7 == 7'b0000000 || (f7 == 7'b0100000 && f3 == 3'd5));

  always_comb begin
    legal   = 1'b1;
    dec     = '0;
    dec.pc  = in_pc;
    dec.rd  = in_instr[11:7];
    dec.rs1 = in_instr[19:15];
    dec.rs2 = in_instr[24:20];
    case (opcode)
      7'b0110111, 7'b0010111: begin
        dec.fmt    = FMT_U;
        dec.imm    = imm_u;
        dec.rs1    = '0;
        dec.rs2    = '0;
        dec.alu_op = opcode[5] ? 5'd18 : 5'd19;
      end
      7'b1101111: begin
        dec.fmt     = FMT_J;
        dec.imm     = imm_j;
        dec.rs1     = '0;
        dec.rs2     = '0;
        dec.is_jump = 1'b1;
        dec.target  = in_pc + imm_j;
      end
      7'b1100111: begin
        dec.fmt     = FMT_I;
        dec.imm     = imm_i;
        dec.rs2     = '0;
        dec.is_jump = 1'b1;
        legal       = (f3 == 3'd0);
      end
      7'b1100011: begin
        dec.fmt       = FMT_B;
        dec.imm       = imm_b;
        dec.rd        = '0;
        dec.is_branch = 1'b1;
        dec.br_cond   = f3;
        dec.target    = in_pc + imm_b;
        legal         = (f3 != 3'd2) && (f3 != 3'd3);
      end
      7'b0000011: begin
        dec.fmt          = FMT_I;
        dec.imm          = imm_i;
        dec.rs2          = '0;
        dec.is_load      = 1'b1;
        dec.mem_size     = f3[1:0];
        dec.mem_unsigned = f3[2];
        legal            = RV64 ? (f3 != 3'd7) : (f3 != 3'd3 && f3 < 3'd6);
      end
      7'b0100011: begin
        dec.fmt      = FMT_S;
        dec.imm      = imm_s;
        dec.rd       = '0;
        dec.is_store = 1'b1;
        dec.mem_size = f3[1:0];
        legal        = (f3 < 3'd3) || (RV64 && f3 == 3'd3);
      end
      7'b0010011: begin
        dec.fmt    = FMT_I;
        dec.imm    = imm_i;
        dec.rs2    = '0;
        dec.alu_op = base_op(f3, in_instr[30] && f3 == 3'd5);
        if (f3 == 3'd1 || f3 == 3'd5) legal = sh_ok;
      end
      7'b0011011: begin
        dec.fmt     = FMT_I;
        dec.imm     = imm_i;
        dec.rs2     = '0;
        dec.is_word = 1'b1;
        dec.alu_op  = base_op(f3, in_instr[30] && f3 == 3'd5);
        legal       = RV64 && (f3 == 3'd0 || (f3 == 3'd1 && f7 == 7'b0000000) ||
                      (f3 == 3'd5 && (f7 == 7'b0000000 || f7 == 7'b0100000)));
      end
      7'b0110011, 7'b0111011: begin
        dec.fmt     = FMT_R;
        dec.is_word = opcode[3];
        if (f7 == 7'b0000001) begin
          dec.alu_op = 5'd10 + {2'b00, f3};
          legal      = M_EN && (!opcode[3] || (f3 == 3'd0 || f3 >= 3'd4));
        end else begin
          dec.alu_op = base_op(f3, f7[5]);
          legal      = (f7 == 7'b0000000 && (!opcode[3] || f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd5)) ||
                       (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
        end
        if (opcode[3] && !RV64) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      dec         = '0;
      dec.pc      = in_pc;
      dec.illegal = 1'b1;
    end
  end

  assign in_ready = !skid_valid;
  assign accept   = in_valid && !skid_valid && !flush;
  assign drain    = head_valid && out_ready;

  // skid only fills while the head is stalled, so it never accepts when in_ready is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head        <= '0;
      skid        <= '0;
      head_valid  <= 1'b0;
      skid_valid  <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (drain && head.illegal && illegal_cnt != {CNT_W{1'b1}})
        illegal_cnt <= illegal_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      if (flush) begin
        head_valid <= 1'b0;
        skid_valid <= 1'b0;
      end else if (drain) begin
        if (skid_valid) begin
          head       <= skid;
          skid_valid <= 1'b0;
        end else if (accept) begin
          head <= dec;
        end else begin
          head_valid <= 1'b0;
        end
      end else if (accept) begin
        if (!head_valid) begin
          head       <= dec;
          head_valid <= 1'b1;
        end else begin
          skid       <= dec;
          skid_valid <= 1'b1;
        end
      end
    end
  end

  assign out_valid        = head_valid;
  assign out_pc           = head.pc;
  assign out_rd           = head.rd;
  assign out_rs1          = head.rs1;
  assign out_rs2          = head.rs2;
  assign out_imm          = head.imm;
  assign out_target       = head.target;
  assign out_alu_op       = head.alu_op;
  assign out_fmt          = head.fmt;
  assign out_is_load      = head.is_load;
  assign out_is_store     = head.is_store;
  assign out_is_branch    = head.is_branch;
  assign out_is_jump      = head.is_jump;
  assign out_is_word      = head.is_word;
  assign out_br_cond      = head.br_cond;
  assign out_mem_size     = head.mem_size;
  assign out_mem_unsigned = head.mem_unsigned;
  assign out_illegal      = head.illegal;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - directed bench for rv_decode_stage, XLEN=64 and XLEN=32 instances
module tb_rv_decode_stage;

`ifdef RV_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, in_valid, flush, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic        in_ready, out_valid;
  logic [63:0] out_pc, out_imm, out_target;
  logic [4:0]  out_rd, out_rs1, out_rs2, out_alu_op;
  logic [2:0]  out_fmt, out_br_cond;
  logic        out_is_load, out_is_store, out_is_branch, out_is_jump, out_is_word;
  logic [1:0]  out_mem_size;
  logic        out_mem_unsigned, out_illegal;
  logic [15:0] illegal_cnt;

  logic        n_in_ready, n_out_valid;
  logic [31:0] n_out_pc, n_out_imm, n_out_target;
  logic [4:0]  n_out_rd, n_out_rs1, n_out_rs2, n_out_alu_op;
  logic [2:0]  n_out_fmt, n_out_br_cond;
  logic        n_out_is_load, n_out_is_store, n_out_is_branch, n_out_is_jump, n_out_is_word;
  logic [1:0]  n_out_mem_size;
  logic        n_out_mem_unsigned, n_out_illegal;
  logic [15:0] n_illegal_cnt;

  rv_decode_stage #(.XLEN(64), .CNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_target(out_target),
    .out_alu_op(out_alu_op), .out_fmt(out_fmt), .out_is_load(out_is_load),
    .out_is_store(out_is_store), .out_is_branch(out_is_branch),
    .out_is_jump(out_is_jump), .out_is_word(out_is_word),
    .out_br_cond(out_br_cond), .out_mem_size(out_mem_size),
    .out_mem_unsigned(out_mem_unsigned), .out_illegal(out_illegal),
    .illegal_cnt(illegal_cnt)
  );

  rv_decode_stage #(.XLEN(32), .CNT_W(16)) dut32 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(n_in_ready),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .flush(flush), .out_valid(n_out_valid),
    .out_ready(out_ready), .out_pc(n_out_pc), .out_rd(n_out_rd), .out_rs1(n_out_rs1),
    .out_rs2(n_out_rs2), .out_imm(n_out_imm), .out_target(n_out_target),
    .out_alu_op(n_out_alu_op), .out_fmt(n_out_fmt), .out_is_load(n_out_is_load),
    .out_is_store(n_out_is_store), .out_is_branch(n_out_is_branch),
    .out_is_jump(n_out_is_jump), .out_is_word(n_out_is_word),
    .out_br_cond(n_out_br_cond), .out_mem_size(n_out_mem_size),
    .out_mem_unsigned(n_out_mem_unsigned), .out_illegal(n_out_illegal),
    .illegal_cnt(n_illegal_cnt)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] instr, input logic [63:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_cnt", illegal_cnt, 0);
    chk("rst_imm", out_imm, 0);

    // addi a0,zero,-1
    out_ready = 1'b1;
    offer(32'hFFF00513, 64'h100); tick();
    chk("addi_valid", out_valid, 1);
    chk("addi_rd", out_rd, 10);
    chk("addi_rs1", out_rs1, 0);
    chk("addi_fmt", out_fmt, 1);
    chk("addi_alu", out_alu_op, 0);
    chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("addi_imm32", n_out_imm, 64'hFFFF_FFFF);

    // bne a0,zero,-4
    offer(32'hFE051EE3, 64'h1000); tick();
    chk("bne_branch", out_is_branch, 1);
    chk("bne_cond", out_br_cond, 1);
    chk("bne_rd", out_rd, 0);
    chk("bne_rs1", out_rs1, 10);
    chk("bne_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("bne_target", out_target, 64'h0FFC);
    chk("bne_fmt", out_fmt, 3);

    // jal ra,+8
    offer(32'h008000EF, 64'h700); tick();
    chk("jal_jump", out_is_jump, 1);
    chk("jal_fmt", out_fmt, 5);
    chk("jal_rd", out_rd, 1);
    chk("jal_target", out_target, 64'h708);
    in_valid = 1'b0; tick();
    chk("idle_valid", out_valid, 0);

    // backpressure: three back-to-back offers with execute stalled
    out_ready = 1'b0;
    offer(32'h00100093, 64'h200); tick();
    chk("bp_ready1", in_ready, 1);
    offer(32'h00200113, 64'h204); tick();
    chk("bp_ready2", in_ready, 0);
    chk("bp_head_a", out_pc, 64'h200);
    offer(32'h00300193, 64'h208); tick();
    chk("bp_ready3", in_ready, 0);
    chk("bp_hold_a", out_rd, 1);
    out_ready = 1'b1; tick();
    chk("bp_b_pc", out_pc, 64'h204);
    chk("bp_b_rd", out_rd, 2);
    chk("bp_ready4", in_ready, 1);
    tick();
    chk("bp_c_pc", out_pc, 64'h208);
    chk("bp_c_rd", out_rd, 3);
    in_valid = 1'b0; tick();
    chk("bp_empty", out_valid, 0);

    // flush with both entries full and a same-cycle offer
    out_ready = 1'b0;
    offer(32'h00100093, 64'h300); tick();
    offer(32'h00200113, 64'h304); tick();
    chk("fl_full", in_ready, 0);
    flush = 1'b1;
    offer(32'h00300193, 64'h308); tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    tick();
    chk("fl_dropped", out_valid, 0);
    offer(32'h00100093, 64'h400); tick();
    in_valid = 1'b0;
    chk("fl_after_valid", out_valid, 1);
    chk("fl_after_pc", out_pc, 64'h400);
    out_ready = 1'b1; tick();
    chk("fl_after_drain", out_valid, 0);

    // illegal word, then ld (illegal only on RV32)
    offer(32'h00000000, 64'h500); tick();
    chk("zero_ill", out_illegal, 1);
    chk("zero_ill32", n_out_illegal, 1);
    chk("zero_rd", out_rd, 0);
    chk("zero_pc", out_pc, 64'h500);
    offer(32'h0005B503, 64'h504); tick();
    chk("ld_cnt1", illegal_cnt, 1);
    chk("ld_load", out_is_load, 1);
    chk("ld_size", out_mem_size, 3);
    chk("ld_ill", out_illegal, 0);
    chk("ld_rs1", out_rs1, 11);
    chk("ld_ill32", n_out_illegal, 1);
    chk("ld_load32", n_out_is_load, 0);
    in_valid = 1'b0; tick();
    chk("ld_cnt64", illegal_cnt, 1);
    chk("ld_cnt32", n_illegal_cnt, 2);

    // mul a0,a1,a2
    offer(32'h02C58533, 64'h600); tick();
    in_valid = 1'b0;
    chk("mul_alu", out_alu_op, M_EN ? 64'd10 : 64'd0);
    chk("mul_ill", out_illegal, M_EN ? 64'd0 : 64'd1);
    chk("mul_rd", out_rd, M_EN ? 64'd10 : 64'd0);
    tick();
    chk("mul_cnt", illegal_cnt, M_EN ? 64'd1 : 64'd2);

    // asynchronous reset mid-stream, sampled between clock edges
    offer(32'h00100093, 64'h700); tick();
    in_valid = 1'b0;
    chk("pre_rst_valid", out_valid, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_rd", out_rd, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_ready", in_ready, 1);
    chk("arst_cnt", illegal_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
